// File: rtl/hermes_cfg_ctrl.sv
// Hermes MAC/IP config controller: shadow register file written over a 32-bit port,
// committed atomically into the active record after the datapath drains.
module hermes_cfg_ctrl #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr_en,
    input  logic        reg_rd_en,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_wr_data,
    output logic [31:0] reg_rd_data,
    output logic        reg_rd_vld,
    input  logic        dp_idle,
    output logic        cfg_vld,
    output logic [47:0] cfg_fpga_mac,
    output logic [31:0] cfg_fpga_ip,
    output logic [47:0] cfg_host_mac,
    output logic [31:0] cfg_host_ip,
    output logic        busy
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWAP,
        ST_SETTLE
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;

    logic [47:0]   sh_fpga_mac_q, sh_fpga_mac_d;
    logic [31:0]   sh_fpga_ip_q, sh_fpga_ip_d;
    logic [47:0]   sh_host_mac_q, sh_host_mac_d;
    logic [31:0]   sh_host_ip_q, sh_host_ip_d;

    logic [47:0]   act_fpga_mac_q, act_fpga_mac_d;
    logic [31:0]   act_fpga_ip_q, act_fpga_ip_d;
    logic [47:0]   act_host_mac_q, act_host_mac_d;
    logic [31:0]   act_host_ip_q, act_host_ip_d;

    logic          cfg_vld_q, cfg_vld_d;
    logic          wr_err_q, wr_err_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   commit_cnt_q, commit_cnt_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_vld_q, rd_vld_d;

    logic          wr_ctrl, wr_shadow, is_idle;
    logic          commit_req, disable_req, clr_wr_err, clr_timeout;
    logic          wr_err_set, timeout_set;
    logic [31:0]   rd_mux, status_word;

    assign is_idle     = (state_q == ST_IDLE);
    assign wr_ctrl     = reg_wr_en && (reg_addr == 3'd6);
    assign wr_shadow   = reg_wr_en && (reg_addr <= 3'd5);
    assign commit_req  = wr_ctrl && reg_wr_data[0];
    assign disable_req = wr_ctrl && reg_wr_data[1];
    assign clr_wr_err  = wr_ctrl && reg_wr_data[2];
    assign clr_timeout = wr_ctrl && reg_wr_data[3];

    assign status_word = {commit_cnt_q, 12'h000, timeout_q, wr_err_q, cfg_vld_q, ~is_idle};

    // Read mux sees only registered state, so a same-cycle write returns the old value.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            3'd0: rd_mux = sh_fpga_mac_q[31:0];
            3'd1: rd_mux = {16'h0000, sh_fpga_mac_q[47:32]};
            3'd2: rd_mux = sh_fpga_ip_q;
            3'd3: rd_mux = sh_host_mac_q[31:0];
            3'd4: rd_mux = {16'h0000, sh_host_mac_q[47:32]};
            3'd5: rd_mux = sh_host_ip_q;
            3'd7: rd_mux = status_word;
            default: rd_mux = '0;
        endcase
    end

    // NOTE: every _d gets its _q as a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        sh_fpga_mac_d  = sh_fpga_mac_q;
        sh_fpga_ip_d   = sh_fpga_ip_q;
        sh_host_mac_d  = sh_host_mac_q;
        sh_host_ip_d   = sh_host_ip_q;
        act_fpga_mac_d = act_fpga_mac_q;
        act_fpga_ip_d  = act_fpga_ip_q;
        act_host_mac_d = act_host_mac_q;
        act_host_ip_d  = act_host_ip_q;
        cfg_vld_d      = cfg_vld_q;
        commit_cnt_d   = commit_cnt_q;
        wr_err_set     = 1'b0;
        timeout_set    = 1'b0;
        rd_vld_d       = reg_rd_en;
        rd_data_d      = reg_rd_en ? rd_mux : 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                    cfg_vld_d   = 1'b0;
                end else if (disable_req) begin
                    cfg_vld_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (dp_idle) begin
                    state_d = ST_SWAP;
                end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
                    state_d     = ST_SWAP;
                    timeout_set = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_SWAP: begin
                act_fpga_mac_d = sh_fpga_mac_q;
                act_fpga_ip_d  = sh_fpga_ip_q;
                act_host_mac_d = sh_host_mac_q;
                act_host_ip_d  = sh_host_ip_q;
                if (commit_cnt_q != 16'hFFFF) begin
                    commit_cnt_d = commit_cnt_q + 16'd1;
                end
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    cfg_vld_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shadow is frozen while a commit is in flight so the swapped record is the one committed.
        if (wr_shadow) begin
            if (is_idle) begin
                case (reg_addr)
                    3'd0: sh_fpga_mac_d[31:0]  = reg_wr_data;
                    3'd1: sh_fpga_mac_d[47:32] = reg_wr_data[15:0];
                    3'd2: sh_fpga_ip_d         = reg_wr_data;
                    3'd3: sh_host_mac_d[31:0]  = reg_wr_data;
                    3'd4: sh_host_mac_d[47:32] = reg_wr_data[15:0];
                    3'd5: sh_host_ip_d         = reg_wr_data;
                    default: ;
                endcase
            end else begin
                wr_err_set = 1'b1;
            end
        end

        wr_err_d  = (wr_err_q & ~clr_wr_err) | wr_err_set;
        timeout_d = (timeout_q & ~clr_timeout) | timeout_set;
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers, including the
    // shadow and active records, are reset so an aborted commit leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            drain_cnt_q    <= '0;
            settle_cnt_q   <= '0;
            sh_fpga_mac_q  <= '0;
            sh_fpga_ip_q   <= '0;
            sh_host_mac_q  <= '0;
            sh_host_ip_q   <= '0;
            act_fpga_mac_q <= '0;
            act_fpga_ip_q  <= '0;
            act_host_mac_q <= '0;
            act_host_ip_q  <= '0;
            cfg_vld_q      <= 1'b0;
            wr_err_q       <= 1'b0;
            timeout_q      <= 1'b0;
            commit_cnt_q   <= '0;
            rd_data_q      <= '0;
            rd_vld_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            sh_fpga_mac_q  <= sh_fpga_mac_d;
            sh_fpga_ip_q   <= sh_fpga_ip_d;
            sh_host_mac_q  <= sh_host_mac_d;
            sh_host_ip_q   <= sh_host_ip_d;
            act_fpga_mac_q <= act_fpga_mac_d;
            act_fpga_ip_q  <= act_fpga_ip_d;
            act_host_mac_q <= act_host_mac_d;
            act_host_ip_q  <= act_host_ip_d;
            cfg_vld_q      <= cfg_vld_d;
            wr_err_q       <= wr_err_d;
            timeout_q      <= timeout_d;
            commit_cnt_q   <= commit_cnt_d;
            rd_data_q      <= rd_data_d;
            rd_vld_q       <= rd_vld_d;
        end
    end

    assign reg_rd_data  = rd_data_q;
    assign reg_rd_vld   = rd_vld_q;
    assign cfg_vld      = cfg_vld_q;
    assign cfg_fpga_mac = act_fpga_mac_q;
    assign cfg_fpga_ip  = act_fpga_ip_q;
    assign cfg_host_mac = act_host_mac_q;
    assign cfg_host_ip  = act_host_ip_q;
    assign busy         = ~is_idle;

endmodule

// File: tb/tb_hermes_cfg_ctrl.sv
// Self-checking bench for hermes_cfg_ctrl: event-timed reference model compared every cycle,
// plus directed literal checks; a second instance runs with a short drain timeout.
module tb_hermes_cfg_ctrl;

    localparam int DRAIN_TO = 1024;
    localparam int SETTLE   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr_en = 1'b0, reg_rd_en = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic        dp_idle = 1'b1;
    logic [31:0] reg_rd_data;
    logic        reg_rd_vld, cfg_vld, busy;
    logic [47:0] cfg_fpga_mac, cfg_host_mac;
    logic [31:0] cfg_fpga_ip, cfg_host_ip;

    logic        to_wr_en = 1'b0, to_rd_en = 1'b0;
    logic [2:0]  to_addr = '0;
    logic [31:0] to_wr_data = '0;
    logic        to_dp_idle = 1'b0;
    logic [31:0] to_rd_data;
    logic        to_rd_vld, to_cfg_vld, to_busy;
    logic [47:0] to_fpga_mac, to_host_mac;
    logic [31:0] to_fpga_ip, to_host_ip;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hermes_cfg_ctrl #(.DRAIN_TIMEOUT(DRAIN_TO), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .reg_rd_vld(reg_rd_vld),
        .dp_idle(dp_idle), .cfg_vld(cfg_vld), .cfg_fpga_mac(cfg_fpga_mac),
        .cfg_fpga_ip(cfg_fpga_ip), .cfg_host_mac(cfg_host_mac), .cfg_host_ip(cfg_host_ip),
        .busy(busy)
    );

    hermes_cfg_ctrl #(.DRAIN_TIMEOUT(16), .SETTLE_CYCLES(SETTLE)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .reg_wr_en(to_wr_en), .reg_rd_en(to_rd_en), .reg_addr(to_addr),
        .reg_wr_data(to_wr_data), .reg_rd_data(to_rd_data), .reg_rd_vld(to_rd_vld),
        .dp_idle(to_dp_idle), .cfg_vld(to_cfg_vld), .cfg_fpga_mac(to_fpga_mac),
        .cfg_fpga_ip(to_fpga_ip), .cfg_host_mac(to_host_mac), .cfg_host_ip(to_host_ip),
        .busy(to_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event-timed commit transaction) ----------------
    logic [31:0] m_sh  [6];
    logic [31:0] m_act [6];
    logic        m_vld, m_err, m_to, m_txn, m_rd_vld;
    logic [15:0] m_cnt;
    logic [31:0] m_rd_data;
    int          cyc, drain_start, swap_cyc;
    logic        was_busy, err_set, to_set;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        if (a <= 3'd5) return m_sh[a];
        if (a == 3'd7) return {m_cnt, 12'h000, m_to, m_err, m_vld, m_txn};
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
            end
            m_vld = 0; m_err = 0; m_to = 0; m_txn = 0; m_cnt = '0;
            m_rd_vld = 0; m_rd_data = '0;
            cyc = 0; drain_start = 0; swap_cyc = -1;
        end else begin
            was_busy  = m_txn;
            err_set   = 0;
            to_set    = 0;
            m_rd_vld  = reg_rd_en;
            m_rd_data = reg_rd_en ? model_read(reg_addr) : 32'h0;
            if (m_txn) begin
                if (swap_cyc < 0) begin
                    if (dp_idle) swap_cyc = cyc + 1;
                    else if (cyc - drain_start + 1 == DRAIN_TO) begin
                        swap_cyc = cyc + 1;
                        to_set   = 1;
                    end
                end else if (cyc == swap_cyc) begin
                    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                if (swap_cyc >= 0 && cyc + 1 == swap_cyc + 1 + SETTLE) begin
                    m_vld = 1;
                    m_txn = 0;
                end
            end
            if (reg_wr_en) begin
                if (reg_addr <= 3'd5) begin
                    if (!was_busy)
                        m_sh[reg_addr] = (reg_addr == 3'd1 || reg_addr == 3'd4) ?
                                         {16'h0, reg_wr_data[15:0]} : reg_wr_data;
                    else
                        err_set = 1;
                end else if (reg_addr == 3'd6) begin
                    if (reg_wr_data[2]) m_err = 0;
                    if (reg_wr_data[3]) m_to = 0;
                    if (!was_busy) begin
                        if (reg_wr_data[0]) begin
                            m_txn = 1; drain_start = cyc + 1; swap_cyc = -1; m_vld = 0;
                        end else if (reg_wr_data[1]) begin
                            m_vld = 0;
                        end
                    end
                end
            end
            if (err_set) m_err = 1;
            if (to_set)  m_to = 1;
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("cmp_cfg_vld", cfg_vld, m_vld);
        check("cmp_busy", busy, m_txn);
        check("cmp_fpga_mac", cfg_fpga_mac, {m_act[1][15:0], m_act[0]});
        check("cmp_fpga_ip", cfg_fpga_ip, m_act[2]);
        check("cmp_host_mac", cfg_host_mac, {m_act[4][15:0], m_act[3]});
        check("cmp_host_ip", cfg_host_ip, m_act[5]);
        check("cmp_rd_vld", reg_rd_vld, m_rd_vld);
        if (m_rd_vld) check("cmp_rd_data", reg_rd_data, m_rd_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wr_en = 1; reg_addr = a; reg_wr_data = d;
        tick();
        reg_wr_en = 0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        reg_rd_en = 1; reg_addr = a;
        tick();
        reg_rd_en = 0;
        check({name, "_vld"}, reg_rd_vld, 1'b1);
        check(name, reg_rd_data, exp);
    endtask

    task automatic to_wr(input logic [2:0] a, input logic [31:0] d);
        to_wr_en = 1; to_addr = a; to_wr_data = d;
        tick();
        to_wr_en = 0;
    endtask

    task automatic to_rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        to_rd_en = 1; to_addr = a;
        tick();
        to_rd_en = 0;
        check(name, to_rd_data, exp);
    endtask

    task automatic wait_vld(output int cnt, input int start);
        cnt = start;
        while (!cfg_vld && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        check("rst_cfg_vld", cfg_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_vld", reg_rd_vld, 1'b0);
        check("rst_rd_data", reg_rd_data, 32'h0);
        check("rst_fpga_mac", cfg_fpga_mac, 48'h0);
        rst_n = 1;
        tick();

        // Test 1: full record, commit with dp_idle=1
        dp_idle = 1;
        wr(3'd0, 32'h2C3D4E5F);
        wr(3'd1, 32'h00000A1B);
        wr(3'd2, 32'hC0A80164);
        wr(3'd3, 32'h22334455);
        wr(3'd4, 32'h00000011);
        wr(3'd5, 32'hC0A80101);
        rd_check("t1_rd_addr0", 3'd0, 32'h2C3D4E5F);
        wr(3'd6, 32'h1);
        wait_vld(n, 1);
        check("t1_vld_latency", n, 7);
        check("t1_fpga_mac", cfg_fpga_mac, 48'h0A1B2C3D4E5F);
        check("t1_fpga_ip", cfg_fpga_ip, 32'hC0A80164);
        check("t1_host_mac", cfg_host_mac, 48'h001122334455);
        check("t1_host_ip", cfg_host_ip, 32'hC0A80101);
        rd_check("t1_status", 3'd7, 32'h0001_0002);

        // Test 2: dp_idle low for 50 drain cycles
        wr(3'd2, 32'h0A000001);
        dp_idle = 0;
        wr(3'd6, 32'h1);
        repeat (50) tick();
        check("t2_busy_d50", busy, 1'b1);
        check("t2_vld_d50", cfg_vld, 1'b0);
        dp_idle = 1;
        tick();
        check("t2_swap_old_ip", cfg_fpga_ip, 32'hC0A80164);
        tick();
        check("t2_new_ip", cfg_fpga_ip, 32'h0A000001);
        check("t2_vld_settle", cfg_vld, 1'b0);
        wait_vld(n, 0);
        check("t2_vld_latency", n, 4);
        rd_check("t2_status", 3'd7, 32'h0002_0002);

        // Test 3: forced swap on the short-timeout instance
        to_dp_idle = 0;
        to_wr(3'd6, 32'h1);
        n = 1;
        while (!to_cfg_vld && n < 40) begin
            tick();
            n++;
        end
        check("t3_forced_vld_latency", n, 22);
        to_rd_check("t3_status_timeout", 3'd7, 32'h0001_000A);
        to_wr(3'd6, 32'h8);
        to_rd_check("t3_status_cleared", 3'd7, 32'h0001_0002);

        // Test 4: write during SETTLE dropped, second commit during DRAIN ignored
        wr(3'd6, 32'h1);
        wr(3'd6, 32'h1);
        tick();
        wr(3'd2, 32'hDEADBEEF);
        wait_vld(n, 4);
        check("t4_vld_latency", n, 7);
        check("t4_active_ip", cfg_fpga_ip, 32'h0A000001);
        rd_check("t4_shadow_ip", 3'd2, 32'h0A000001);
        rd_check("t4_status_err", 3'd7, 32'h0003_0006);
        wr(3'd6, 32'h4);
        rd_check("t4_status_clr", 3'd7, 32'h0003_0002);

        // Test 5: disable keeps fields; reset during DRAIN aborts
        wr(3'd6, 32'h2);
        check("t5_disable_vld", cfg_vld, 1'b0);
        check("t5_disable_ip", cfg_fpga_ip, 32'h0A000001);
        dp_idle = 0;
        wr(3'd6, 32'h1);
        repeat (3) tick();
        check("t5_drain_busy", busy, 1'b1);
        #2 rst_n = 0;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_vld", cfg_vld, 1'b0);
        check("t5_rst_ip", cfg_fpga_ip, 32'h0);
        check("t5_rst_mac", cfg_fpga_mac, 48'h0);
        @(posedge clk);
        #1 rst_n = 1;
        dp_idle = 1;
        tick();
        rd_check("t5_status_after_rst", 3'd7, 32'h0);

        // Test 6: upper half of addr 1 ignored; read/write same cycle
        wr(3'd1, 32'hFFFF1234);
        rd_check("t6_rd_addr1", 3'd1, 32'h00001234);
        tick();
        check("t6_rd_vld_pulse", reg_rd_vld, 1'b0);
        reg_wr_en = 1; reg_rd_en = 1; reg_addr = 3'd0; reg_wr_data = 32'hAAAA5555;
        tick();
        reg_wr_en = 0; reg_rd_en = 0;
        check("t6_rw_pre_value", reg_rd_data, 32'h0);
        rd_check("t6_rw_post_value", 3'd0, 32'hAAAA5555);
        rd_check("t6_ctrl_reads0", 3'd6, 32'h0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
